// File: rtl/cache_refill_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cache_refill_ctrl
// Purpose  : Miss handler for a 2-way set-associative cache table. Picks a
//            victim way, writes back a dirty victim, fetches the 4-word line,
//            merges store data for store misses and issues one full-line
//            table write. Owns the per-set replacement state.
// Ports    : miss_*  - miss request and store payload (accepted in IDLE)
//            tbl_*   - table read data in / full-entry write out
//            hit_*   - pipeline hits, refresh the replacement bit
//            rd_*    - memory line read request / ret_* returned words
//            wr_*    - victim writeback request
//            refill_done_o - one-cycle pulse after the table write
// Options  : define CACHE_LFSR_REPLACE_EN to replace the LRU array with an
//            8-bit Fibonacci LFSR (taps 8,6,5,4) victim chooser.
// Revision : 1.0 - initial release
// ============================================================================
module cache_refill_ctrl #(
   parameter int INDEX_W    = 8,
   parameter int TAG_W      = 20,
   parameter int LINE_WORDS = 4
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           miss_valid_i,
   output logic                           miss_ready_o,
   input  logic [INDEX_W-1:0]             miss_index_i,
   input  logic [TAG_W-1:0]               miss_tag_i,
   input  logic                           miss_wr_i,
   input  logic [3:0]                     miss_offset_i,
   input  logic [3:0]                     miss_wstrb_i,
   input  logic [31:0]                    miss_wdata_i,
   input  logic [2*(TAG_W+2+32*LINE_WORDS)-1:0] tbl_rdata_i,
   input  logic                           hit_valid_i,
   input  logic [INDEX_W-1:0]             hit_index_i,
   input  logic                           hit_way_i,
   output logic                           tbl_req_o,
   output logic                           tbl_way_o,
   output logic [INDEX_W-1:0]             tbl_index_o,
   output logic [1:0]                     tbl_wtype_o,
   output logic [TAG_W+2+32*LINE_WORDS-1:0] tbl_wdata_o,
   output logic                           rd_req_o,
   output logic [31:0]                    rd_addr_o,
   input  logic                           rd_rdy_i,
   input  logic                           ret_valid_i,
   input  logic                           ret_last_i,
   input  logic [31:0]                    ret_data_i,
   output logic                           wr_req_o,
   output logic [31:0]                    wr_addr_o,
   output logic [32*LINE_WORDS-1:0]       wr_data_o,
   input  logic                           wr_rdy_i,
   output logic                           refill_done_o
);

   localparam int DATA_W  = 32 * LINE_WORDS;
   localparam int ENTRY_W = TAG_W + 2 + DATA_W;
   localparam int V_BIT   = DATA_W + 1;
   localparam int D_BIT   = DATA_W;

   typedef enum logic [2:0] {IDLE, WB, RD, REFILL, WRITE} state_t;
   state_t state, state_nxt;

   logic [INDEX_W-1:0] m_index;
   logic [TAG_W-1:0]   m_tag;
   logic               m_wr;
   logic [1:0]         m_word;
   logic [3:0]         m_wstrb;
   logic [31:0]        m_wdata;
   logic               victim;
   logic [TAG_W-1:0]   vic_tag;
   logic [DATA_W-1:0]  vic_data;
   logic [DATA_W-1:0]  line;
   logic [DATA_W-1:0]  merged;
   logic [1:0]         cnt;
   logic               done;

   logic [ENTRY_W-1:0] way0, way1, vic_entry;
   logic               repl_way, victim_sel, accept;

   assign way0   = tbl_rdata_i[ENTRY_W-1:0];
   assign way1   = tbl_rdata_i[2*ENTRY_W-1:ENTRY_W];
   assign accept = miss_valid_i && (state == IDLE);

`ifdef CACHE_LFSR_REPLACE_EN
   logic [7:0] lfsr;
   logic       unused;

   assign repl_way = lfsr[0];
   assign unused   = ^{miss_offset_i[1:0], hit_valid_i, hit_index_i, hit_way_i};

   always_ff @(posedge clk) begin
      if (!rst_n) lfsr <= 8'h01;
      else        lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
   end
`else
   logic [(1<<INDEX_W)-1:0] lru;
   logic                    unused;

   assign unused = ^miss_offset_i[1:0];

   // The refill's own LRU update lands at the end of the done cycle (so it
   // beats a same-cycle hit); forward it to a miss accepted in that cycle.
   assign repl_way = (done && (m_index == miss_index_i)) ? ~victim : lru[miss_index_i];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         lru <= '0;
      end else begin
         if (hit_valid_i) lru[hit_index_i] <= ~hit_way_i;
         if (done)        lru[m_index]     <= ~victim;   // later assignment wins
      end
   end
`endif

   assign victim_sel = !way0[V_BIT] ? 1'b0 : (!way1[V_BIT] ? 1'b1 : repl_way);
   assign vic_entry  = victim_sel ? way1 : way0;

   // Store data merged into the refilled line at the selected word.
   always_comb begin
      merged = line;
      if (m_wr) begin
         for (int b = 0; b < 4; b++) begin
            if (m_wstrb[b]) merged[int'(m_word)*32 + b*8 +: 8] = m_wdata[b*8 +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt     = state;
      miss_ready_o  = 1'b0;
      tbl_req_o     = 1'b0;
      tbl_way_o     = 1'b0;
      tbl_index_o   = '0;
      tbl_wtype_o   = 2'b00;
      tbl_wdata_o   = '0;
      rd_req_o      = 1'b0;
      rd_addr_o     = '0;
      wr_req_o      = 1'b0;
      wr_addr_o     = '0;
      wr_data_o     = '0;
      refill_done_o = done;
      case (state)
         IDLE: begin
            miss_ready_o = 1'b1;
            if (miss_valid_i)
               state_nxt = (vic_entry[V_BIT] && vic_entry[D_BIT]) ? WB : RD;
         end
         WB: begin
            wr_req_o  = 1'b1;
            wr_addr_o = {vic_tag, m_index, 4'b0000};
            wr_data_o = vic_data;
            if (wr_rdy_i) state_nxt = RD;
         end
         RD: begin
            rd_req_o  = 1'b1;
            rd_addr_o = {m_tag, m_index, 4'b0000};
            if (rd_rdy_i) state_nxt = REFILL;
         end
         REFILL: begin
            if (ret_valid_i && ret_last_i) state_nxt = WRITE;
         end
         WRITE: begin
            tbl_req_o   = 1'b1;
            tbl_way_o   = victim;
            tbl_index_o = m_index;
            tbl_wtype_o = 2'b10;
            tbl_wdata_o = {m_tag, 1'b1, m_wr, merged};
            state_nxt   = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         m_index  <= '0;
         m_tag    <= '0;
         m_wr     <= 1'b0;
         m_word   <= '0;
         m_wstrb  <= '0;
         m_wdata  <= '0;
         victim   <= 1'b0;
         vic_tag  <= '0;
         vic_data <= '0;
         line     <= '0;
         cnt      <= '0;
         done     <= 1'b0;
      end else begin
         done <= (state == WRITE);
         if (accept) begin
            m_index  <= miss_index_i;
            m_tag    <= miss_tag_i;
            m_wr     <= miss_wr_i;
            m_word   <= miss_offset_i[3:2];
            m_wstrb  <= miss_wstrb_i;
            m_wdata  <= miss_wdata_i;
            victim   <= victim_sel;
            vic_tag  <= vic_entry[ENTRY_W-1 -: TAG_W];
            vic_data <= vic_entry[DATA_W-1:0];
            cnt      <= '0;
         end
         // Short bursts leave the unreturned words with their previous contents.
         if ((state == REFILL) && ret_valid_i) begin
            line[int'(cnt)*32 +: 32] <= ret_data_i;
            cnt                      <= cnt + 2'd1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_cache_refill_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_refill_ctrl
// Purpose  : Directed self-checking bench for cache_refill_ctrl (LRU build).
// Revision : 1.0 - initial release
// ============================================================================
module tb_cache_refill_ctrl;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          miss_valid_i;
   logic          miss_ready_o;
   logic [7:0]    miss_index_i;
   logic [19:0]   miss_tag_i;
   logic          miss_wr_i;
   logic [3:0]    miss_offset_i;
   logic [3:0]    miss_wstrb_i;
   logic [31:0]   miss_wdata_i;
   logic [299:0]  tbl_rdata_i;
   logic          hit_valid_i;
   logic [7:0]    hit_index_i;
   logic          hit_way_i;
   logic          tbl_req_o;
   logic          tbl_way_o;
   logic [7:0]    tbl_index_o;
   logic [1:0]    tbl_wtype_o;
   logic [149:0]  tbl_wdata_o;
   logic          rd_req_o;
   logic [31:0]   rd_addr_o;
   logic          rd_rdy_i;
   logic          ret_valid_i;
   logic          ret_last_i;
   logic [31:0]   ret_data_i;
   logic          wr_req_o;
   logic [31:0]   wr_addr_o;
   logic [127:0]  wr_data_o;
   logic          wr_rdy_i;
   logic          refill_done_o;

   int total = 0;
   int bad   = 0;

   cache_refill_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .miss_valid_i(miss_valid_i), .miss_ready_o(miss_ready_o),
      .miss_index_i(miss_index_i), .miss_tag_i(miss_tag_i), .miss_wr_i(miss_wr_i),
      .miss_offset_i(miss_offset_i), .miss_wstrb_i(miss_wstrb_i), .miss_wdata_i(miss_wdata_i),
      .tbl_rdata_i(tbl_rdata_i),
      .hit_valid_i(hit_valid_i), .hit_index_i(hit_index_i), .hit_way_i(hit_way_i),
      .tbl_req_o(tbl_req_o), .tbl_way_o(tbl_way_o), .tbl_index_o(tbl_index_o),
      .tbl_wtype_o(tbl_wtype_o), .tbl_wdata_o(tbl_wdata_o),
      .rd_req_o(rd_req_o), .rd_addr_o(rd_addr_o), .rd_rdy_i(rd_rdy_i),
      .ret_valid_i(ret_valid_i), .ret_last_i(ret_last_i), .ret_data_i(ret_data_i),
      .wr_req_o(wr_req_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o), .wr_rdy_i(wr_rdy_i),
      .refill_done_o(refill_done_o)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [149:0] obs, input logic [149:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [149:0] ent(input logic [19:0] tag, input logic v, input logic d,
                                        input logic [127:0] data);
      return {tag, v, d, data};
   endfunction

   task automatic miss(input logic [7:0] idx, input logic [19:0] tag, input logic wr,
                       input logic [3:0] off, input logic [3:0] strb, input logic [31:0] wd,
                       input logic [149:0] e1, input logic [149:0] e0);
      chk("miss_ready_before", {149'd0, miss_ready_o}, 150'd1);
      miss_valid_i  = 1'b1;
      miss_index_i  = idx;
      miss_tag_i    = tag;
      miss_wr_i     = wr;
      miss_offset_i = off;
      miss_wstrb_i  = strb;
      miss_wdata_i  = wd;
      tbl_rdata_i   = {e1, e0};
      step();
      miss_valid_i  = 1'b0;
      tbl_rdata_i   = '0;
      chk("miss_ready_after", {149'd0, miss_ready_o}, 150'd0);
   endtask

   task automatic rd_phase(input logic [31:0] addr);
      chk("rd_req", {149'd0, rd_req_o}, 150'd1);
      chk("rd_addr", {118'd0, rd_addr_o}, {118'd0, addr});
      chk("wr_req_in_rd", {149'd0, wr_req_o}, 150'd0);
      step();
      chk("rd_addr_held", {118'd0, rd_addr_o}, {118'd0, addr});
      rd_rdy_i = 1'b1;
      step();
      rd_rdy_i = 1'b0;
      chk("rd_req_dropped", {149'd0, rd_req_o}, 150'd0);
   endtask

   task automatic returns(input logic [31:0] w0, input logic [31:0] w1,
                          input logic [31:0] w2, input logic [31:0] w3);
      logic [31:0] w [4];
      w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
      for (int i = 0; i < 4; i++) begin
         ret_valid_i = 1'b1;
         ret_data_i  = w[i];
         ret_last_i  = (i == 3);
         step();
      end
      ret_valid_i = 1'b0;
      ret_last_i  = 1'b0;
   endtask

   task automatic write_check(input logic way, input logic [7:0] idx, input logic [149:0] wdata,
                              input logic inj, input logic [7:0] hidx, input logic hway);
      chk("tbl_req", {149'd0, tbl_req_o}, 150'd1);
      chk("tbl_wtype", {148'd0, tbl_wtype_o}, 150'd2);
      chk("tbl_way", {149'd0, tbl_way_o}, {149'd0, way});
      chk("tbl_index", {142'd0, tbl_index_o}, {142'd0, idx});
      chk("tbl_wdata", tbl_wdata_o, wdata);
      chk("done_early", {149'd0, refill_done_o}, 150'd0);
      step();
      chk("refill_done", {149'd0, refill_done_o}, 150'd1);
      chk("tbl_req_off", {149'd0, tbl_req_o}, 150'd0);
      chk("tbl_wtype_off", {148'd0, tbl_wtype_o}, 150'd0);
      hit_valid_i = inj;
      hit_index_i = hidx;
      hit_way_i   = hway;
      step();
      hit_valid_i = 1'b0;
      chk("refill_done_pulse", {149'd0, refill_done_o}, 150'd0);
   endtask

   initial begin
      rst_n = 1'b0;
      miss_valid_i = 1'b0; miss_index_i = '0; miss_tag_i = '0; miss_wr_i = 1'b0;
      miss_offset_i = '0; miss_wstrb_i = '0; miss_wdata_i = '0; tbl_rdata_i = '0;
      hit_valid_i = 1'b0; hit_index_i = '0; hit_way_i = 1'b0;
      rd_rdy_i = 1'b0; ret_valid_i = 1'b0; ret_last_i = 1'b0; ret_data_i = '0;
      wr_rdy_i = 1'b0;
      step(); step();

      // Reset state
      chk("rst_miss_ready", {149'd0, miss_ready_o}, 150'd1);
      chk("rst_tbl_req", {149'd0, tbl_req_o}, 150'd0);
      chk("rst_tbl_wtype", {148'd0, tbl_wtype_o}, 150'd0);
      chk("rst_rd_req", {149'd0, rd_req_o}, 150'd0);
      chk("rst_wr_req", {149'd0, wr_req_o}, 150'd0);
      chk("rst_done", {149'd0, refill_done_o}, 150'd0);
      chk("rst_tbl_wdata", tbl_wdata_o, 150'd0);
      rst_n = 1'b1;
      step();

      // Clean miss, both ways invalid -> way0, no writeback
      miss(8'h12, 20'hABCDE, 1'b0, 4'h0, 4'h0, 32'h0, 150'd0, 150'd0);
      chk("clean_no_wr", {149'd0, wr_req_o}, 150'd0);
      rd_phase(32'hABCDE120);
      returns(32'h11, 32'h22, 32'h33, 32'h44);
      write_check(1'b0, 8'h12,
                  ent(20'hABCDE, 1'b1, 1'b0, 128'h00000044_00000033_00000022_00000011),
                  1'b0, 8'h0, 1'b0);
      // LRU[0x12] is now 1

      // Dirty victim on way1 (both valid, LRU=1)
      miss(8'h12, 20'h12345, 1'b0, 4'h0, 4'h0, 32'h0,
           ent(20'h00055, 1'b1, 1'b1, 128'h01234567_89ABCDEF_FEDCBA98_76543210),
           ent(20'hABCDE, 1'b1, 1'b0, 128'h5));
      for (int i = 0; i < 3; i++) begin
         chk("wb_req", {149'd0, wr_req_o}, 150'd1);
         chk("wb_addr", {118'd0, wr_addr_o}, {118'd0, 32'h00055120});
         chk("wb_data", {22'd0, wr_data_o}, {22'd0, 128'h01234567_89ABCDEF_FEDCBA98_76543210});
         chk("wb_no_rd", {149'd0, rd_req_o}, 150'd0);
         step();
      end
      wr_rdy_i = 1'b1;
      step();
      wr_rdy_i = 1'b0;
      chk("wb_dropped", {149'd0, wr_req_o}, 150'd0);
      rd_phase(32'h12345120);
      returns(32'hA0, 32'hA1, 32'hA2, 32'hA3);
      write_check(1'b1, 8'h12,
                  ent(20'h12345, 1'b1, 1'b0, 128'h000000A3_000000A2_000000A1_000000A0),
                  1'b0, 8'h0, 1'b0);

      // Store miss: offset 6 -> word1, bytes 3:2 replaced
      miss(8'h30, 20'h0BEEF, 1'b1, 4'h6, 4'b1100, 32'hDEAD0000, 150'd0, 150'd0);
      rd_phase(32'h0BEEF300);
      returns(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
      write_check(1'b0, 8'h30,
                  ent(20'h0BEEF, 1'b1, 1'b1, 128'h44444444_33333333_DEAD2222_11111111),
                  1'b0, 8'h0, 1'b0);

      // Hit on set 5 way0 -> LRU[5]=1 -> victim way1 on next miss
      hit_valid_i = 1'b1; hit_index_i = 8'h05; hit_way_i = 1'b0;
      step();
      hit_valid_i = 1'b0;
      miss(8'h05, 20'h00C00, 1'b0, 4'h0, 4'h0, 32'h0,
           ent(20'h00B00, 1'b1, 1'b0, 128'h1), ent(20'h00A00, 1'b1, 1'b0, 128'h2));
      chk("lru_no_wr", {149'd0, wr_req_o}, 150'd0);
      rd_phase(32'h00C00050);
      returns(32'h1, 32'h2, 32'h3, 32'h4);
      write_check(1'b1, 8'h05,
                  ent(20'h00C00, 1'b1, 1'b0, 128'h00000004_00000003_00000002_00000001),
                  1'b0, 8'h0, 1'b0);
      // LRU[5]=0 -> victim way0; same-cycle hit way1 during done must lose
      miss(8'h05, 20'h00D00, 1'b0, 4'h0, 4'h0, 32'h0,
           ent(20'h00C00, 1'b1, 1'b0, 128'h1), ent(20'h00A00, 1'b1, 1'b0, 128'h2));
      rd_phase(32'h00D00050);
      returns(32'h5, 32'h6, 32'h7, 32'h8);
      write_check(1'b0, 8'h05,
                  ent(20'h00D00, 1'b1, 1'b0, 128'h00000008_00000007_00000006_00000005),
                  1'b1, 8'h05, 1'b1);
      // LRU[5] should be 1 -> way1
      miss(8'h05, 20'h00E00, 1'b0, 4'h0, 4'h0, 32'h0,
           ent(20'h00C00, 1'b1, 1'b0, 128'h1), ent(20'h00D00, 1'b1, 1'b0, 128'h2));
      rd_phase(32'h00E00050);
      returns(32'h9, 32'hA, 32'hB, 32'hC);
      write_check(1'b1, 8'h05,
                  ent(20'h00E00, 1'b1, 1'b0, 128'h0000000C_0000000B_0000000A_00000009),
                  1'b0, 8'h0, 1'b0);

      // Reset during REFILL after 2 words
      miss(8'h40, 20'h00F00, 1'b0, 4'h0, 4'h0, 32'h0, 150'd0, 150'd0);
      rd_phase(32'h00F00400);
      for (int i = 0; i < 2; i++) begin
         ret_valid_i = 1'b1; ret_data_i = 32'h77; ret_last_i = 1'b0;
         step();
      end
      ret_valid_i = 1'b0;
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      chk("abort_ready", {149'd0, miss_ready_o}, 150'd1);
      chk("abort_rd_req", {149'd0, rd_req_o}, 150'd0);
      chk("abort_tbl_req", {149'd0, tbl_req_o}, 150'd0);
      for (int i = 0; i < 4; i++) begin
         ret_valid_i = 1'b1; ret_last_i = (i == 1); ret_data_i = 32'h88;
         step();
         chk("abort_no_write", {149'd0, tbl_req_o}, 150'd0);
         chk("abort_no_done", {149'd0, refill_done_o}, 150'd0);
      end
      ret_valid_i = 1'b0; ret_last_i = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
